// File: rtl/snake_pkg.sv
// Shared encodings for the snake head controller: key codes, heading, FSM states.
package snake_pkg;

  localparam logic [2:0] DIR_RIGHT = 3'b000;
  localparam logic [2:0] DIR_DOWN  = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_UP    = 3'b011;
  localparam logic [2:0] DIR_PAUSE = 3'b100;

  typedef enum logic [1:0] {
    HEAD_RIGHT = 2'b00,
    HEAD_DOWN  = 2'b01,
    HEAD_LEFT  = 2'b10,
    HEAD_UP    = 2'b11
  } heading_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  // Opposite headings differ only in bit 1 (right/left, down/up).
  function automatic logic is_reverse(input heading_t a, input heading_t b);
    return (a ^ b) == 2'b10;
  endfunction

  function automatic logic is_legal(input logic [2:0] code);
    return code <= DIR_PAUSE;
  endfunction

endpackage

// File: rtl/ps2_dir_sync.sv
// Brings the keyboard direction code into the clk domain, filters it for
// stability and legality, and flags each change of the filtered code.
module ps2_dir_sync
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] direction,
  output logic [2:0] dir_stable,
  output logic       dir_event
);

  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;
  logic [2:0] stable_q;
  logic       vld_p1;
  logic       vld_p2;
  logic       vld_p3;
  logic       seen;
  logic       load;

  // vld_pN keeps the reset contents of s1..s3 from being taken as a real key code.
  assign load       = vld_p3 && (s2 == s3) && is_legal(s2);
  assign dir_stable = load ? s2 : stable_q;
  assign dir_event  = seen && (dir_stable != stable_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      stable_q <= '0;
      seen     <= 1'b0;
    end else begin
      s1     <= direction;
      s2     <= s1;
      s3     <= s2;
      vld_p1 <= 1'b1;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (load) begin
        stable_q <= s2;
        seen     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: run/pause FSM, step timer and wrapping head position,
// driven by filtered keyboard direction events.
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int STEP_DIV = 5000000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                direction,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic [1:0]                heading,
  output logic                      step_pulse,
  output logic                      running
);

  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  heading_t         pending;
  heading_t         heading_q;
  heading_t         code_head;
  logic [CNT_W-1:0] count;
  logic [2:0]       dir_stable;
  logic             dir_event;
  logic             move_evt;
  logic             pause_evt;
  logic             accept;
  logic             step;

  function automatic logic [X_W-1:0] next_x(input logic [X_W-1:0] x, input heading_t h);
    next_x = x;
    if (h == HEAD_RIGHT)     next_x = (x == X_MAX) ? '0 : x + X_W'(1);
    else if (h == HEAD_LEFT) next_x = (x == '0) ? X_MAX : x - X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] y, input heading_t h);
    next_y = y;
    if (h == HEAD_DOWN)    next_y = (y == Y_MAX) ? '0 : y + Y_W'(1);
    else if (h == HEAD_UP) next_y = (y == '0) ? Y_MAX : y - Y_W'(1);
  endfunction

  ps2_dir_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .direction  (direction),
    .dir_stable (dir_stable),
    .dir_event  (dir_event)
  );

  assign code_head = heading_t'(dir_stable[1:0]);
  assign pause_evt = dir_event && (dir_stable == DIR_PAUSE);
  assign move_evt  = dir_event && (dir_stable != DIR_PAUSE);
  // Reverse check is against the heading committed before any step this cycle.
  assign accept    = move_evt && !is_reverse(heading_q, code_head);
  assign running   = (state == ST_RUN);
  // A pause arriving on the step cycle suppresses the step entirely.
  assign step      = running && (count == CNT_LAST) && !pause_evt;
  assign heading   = heading_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (move_evt)  state_nxt = ST_RUN;
      ST_RUN:    if (pause_evt) state_nxt = ST_PAUSED;
      ST_PAUSED: if (move_evt)  state_nxt = ST_RUN;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Step timer and position update; the step consumes the pending heading
  // as it stood before any event landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      pending    <= HEAD_RIGHT;
      heading_q  <= HEAD_RIGHT;
      head_x     <= X_W'(START_X);
      head_y     <= Y_W'(START_Y);
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step;
      if (running && !pause_evt) count <= step ? '0 : count + CNT_W'(1);
      else                       count <= '0;
      if (accept) pending <= code_head;
      if (step) begin
        heading_q <= pending;
        head_x    <= next_x(head_x, pending);
        head_y    <= next_y(head_y, pending);
      end
    end
  end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: directed scenarios plus random key traffic
// compared against a cycle-level behavioural model of the head controller.
module tb_snake_head_ctrl;

  localparam int GW = 8;
  localparam int GH = 6;
  localparam int SD = 4;
  localparam int SX = 4;
  localparam int SY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] direction = 3'b000;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic [1:0] heading;
  logic       step_pulse;
  logic       running;

  int checks = 0;
  int passes = 0;

  // Behavioural model state (0 idle, 1 run, 2 paused).
  int m_p1, m_p2, m_p3, m_n, m_stab, m_st, m_cnt, m_x, m_y, m_head, m_pend, m_old, m_code;
  bit m_seen, m_pulse, m_ld, m_ev, m_pz, m_mv, m_stp;

  snake_head_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .STEP_DIV(SD), .START_X(SX), .START_Y(SY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .direction  (direction),
    .head_x     (head_x),
    .head_y     (head_y),
    .heading    (heading),
    .step_pulse (step_pulse),
    .running    (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_p1 = 0; m_p2 = 0; m_p3 = 0; m_n = 0; m_stab = 0; m_seen = 0;
      m_st = 0; m_cnt = 0; m_x = SX; m_y = SY; m_head = 0; m_pend = 0; m_pulse = 0;
    end else begin
      // A legal code seen on two successive synchronised samples becomes stable.
      m_ld   = (m_n >= 3) && (m_p2 == m_p3) && (m_p2 <= 4);
      m_code = m_p2;
      m_ev   = m_ld && m_seen && (m_code != m_stab);
      if (m_ld) begin m_stab = m_code; m_seen = 1; end
      m_pz  = m_ev && (m_code == 4);
      m_mv  = m_ev && (m_code != 4);
      m_stp = (m_st == 1) && (m_cnt == SD - 1) && !m_pz;
      m_old = m_head;
      m_pulse = m_stp;
      if (m_stp) begin
        m_head = m_pend;
        case (m_pend)
          0: m_x = (m_x + 1) % GW;
          1: m_y = (m_y + 1) % GH;
          2: m_x = (m_x + GW - 1) % GW;
          default: m_y = (m_y + GH - 1) % GH;
        endcase
      end
      if (m_mv && !(m_old != m_code && (m_old % 2) == (m_code % 2))) m_pend = m_code;
      m_cnt = (m_st == 1 && !m_pz) ? (m_stp ? 0 : m_cnt + 1) : 0;
      if (m_st == 0 && m_mv) m_st = 1;
      else if (m_st == 1 && m_pz) m_st = 2;
      else if (m_st == 2 && m_mv) m_st = 1;
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = int'(direction);
      if (m_n < 3) m_n++;
    end
  end

  task automatic wait_step(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (step_pulse === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b0; direction = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if ({head_x, head_y, heading, step_pulse, running} !== {3'd4, 3'd3, 2'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: got x=%0d y=%0d hd=%0d sp=%0d run=%0d want x=4 y=3 hd=0 sp=0 run=0",
               head_x, head_y, heading, step_pulse, running);
    else passes++;
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (running !== 1'b0 || step_pulse !== 1'b0 || head_x !== 3'd4 || head_y !== 3'd3) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL baseline_only: got run=%0d x=%0d y=%0d want run=0 x=4 y=3", running, head_x, head_y);
    else passes++;
  endtask

  task automatic test_start_up();
    int cyc;
    int exp_y[3];
    exp_y = '{1, 0, 5};
    direction = 3'b011;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0) $display("FAIL start_early: running=%0d want 0", running); else passes++;
    @(negedge clk);
    checks++;
    if (running !== 1'b1) $display("FAIL start_latency: running=%0d want 1", running); else passes++;
    wait_step(cyc);
    checks++;
    if (cyc != 4 || head_x !== 3'd4 || head_y !== 3'd2 || heading !== 2'b11)
      $display("FAIL first_step: cyc=%0d x=%0d y=%0d hd=%0d want cyc=4 x=4 y=2 hd=3", cyc, head_x, head_y, heading);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      wait_step(cyc);
      checks++;
      if (cyc != 4 || head_x !== 3'd4 || head_y !== 3'(exp_y[k]) || heading !== 2'b11)
        $display("FAIL up_step%0d: cyc=%0d x=%0d y=%0d want cyc=4 x=4 y=%0d", k, cyc, head_x, head_y, exp_y[k]);
      else passes++;
    end
  endtask

  task automatic test_wrap_right();
    int cyc;
    direction = 3'b000;
    wait_step(cyc);
    checks++;
    if (cyc != 4 || head_x !== 3'd4 || head_y !== 3'd4 || heading !== 2'b11)
      $display("FAIL move_during_step: cyc=%0d x=%0d y=%0d hd=%0d want cyc=4 x=4 y=4 hd=3", cyc, head_x, head_y, heading);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      wait_step(cyc);
      checks++;
      if (cyc != 4 || head_x !== 3'((5 + k) % GW) || head_y !== 3'd4 || heading !== 2'b00)
        $display("FAIL right_step%0d: cyc=%0d x=%0d y=%0d hd=%0d want x=%0d y=4 hd=0", k, cyc, head_x, head_y, heading, (5 + k) % GW);
      else passes++;
    end
  endtask

  task automatic test_reverse();
    int cyc;
    direction = 3'b010;
    for (int k = 1; k <= 2; k++) begin
      wait_step(cyc);
      checks++;
      if (cyc != 4 || head_x !== 3'(k) || heading !== 2'b00)
        $display("FAIL reverse_rejected%0d: cyc=%0d x=%0d hd=%0d want x=%0d hd=0", k, cyc, head_x, heading, k);
      else passes++;
    end
    direction = 3'b001;
    wait_step(cyc);
    wait_step(cyc);
    checks++;
    if (cyc != 4 || head_x !== 3'd3 || head_y !== 3'd5 || heading !== 2'b01)
      $display("FAIL turn_down: cyc=%0d x=%0d y=%0d hd=%0d want x=3 y=5 hd=1", cyc, head_x, head_y, heading);
    else passes++;
  endtask

  task automatic test_wrap_left();
    int cyc;
    int exp_x[4];
    exp_x = '{2, 1, 0, 7};
    direction = 3'b010;
    wait_step(cyc);
    checks++;
    if (cyc != 4 || head_x !== 3'd3 || head_y !== 3'd0 || heading !== 2'b01)
      $display("FAIL wrap_down: cyc=%0d x=%0d y=%0d hd=%0d want x=3 y=0 hd=1", cyc, head_x, head_y, heading);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      wait_step(cyc);
      checks++;
      if (cyc != 4 || head_x !== 3'(exp_x[k]) || head_y !== 3'd0 || heading !== 2'b10)
        $display("FAIL left_step%0d: cyc=%0d x=%0d y=%0d hd=%0d want x=%0d y=0 hd=2", k, cyc, head_x, head_y, heading, exp_x[k]);
      else passes++;
    end
  endtask

  task automatic test_pause();
    int cyc;
    bit bad;
    direction = 3'b100;
    bad = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (step_pulse !== 1'b0 || head_x !== 3'd7 || head_y !== 3'd0) bad = 1;
      if (i == 3 && running !== 1'b1) bad = 1;
      if (i >= 4 && running !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL pause_frozen: got sp=%0d run=%0d x=%0d y=%0d want sp=0 run=0 x=7 y=0", step_pulse, running, head_x, head_y);
    else passes++;
    direction = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (running !== 1'b0) $display("FAIL resume_early: running=%0d want 0", running); else passes++;
    @(negedge clk);
    checks++;
    if (running !== 1'b1) $display("FAIL resume_latency: running=%0d want 1", running); else passes++;
    wait_step(cyc);
    checks++;
    if (cyc != 4 || head_x !== 3'd6 || head_y !== 3'd0 || heading !== 2'b10)
      $display("FAIL resume_step: cyc=%0d x=%0d y=%0d hd=%0d want cyc=4 x=6 y=0 hd=2", cyc, head_x, head_y, heading);
    else passes++;
  endtask

  task automatic test_async_reset();
    int cyc;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({head_x, head_y, heading, step_pulse, running} !== {3'd4, 3'd3, 2'd0, 1'b0, 1'b0})
      $display("FAIL async_reset: got x=%0d y=%0d hd=%0d sp=%0d run=%0d want x=4 y=3 hd=0 sp=0 run=0",
               head_x, head_y, heading, step_pulse, running);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (running !== 1'b0 || head_x !== 3'd4 || head_y !== 3'd3)
      $display("FAIL post_reset_idle: run=%0d x=%0d y=%0d want run=0 x=4 y=3", running, head_x, head_y);
    else passes++;
    direction = 3'b011;
    repeat (4) @(negedge clk);
    wait_step(cyc);
    checks++;
    if (cyc != 4 || head_x !== 3'd4 || head_y !== 3'd2 || heading !== 2'b11)
      $display("FAIL restart_step: cyc=%0d x=%0d y=%0d hd=%0d want cyc=4 x=4 y=2 hd=3", cyc, head_x, head_y, heading);
    else passes++;
  endtask

  task automatic test_random();
    int hold;
    int r;
    logic [9:0] exp_v;
    logic [9:0] got_v;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      exp_v = {3'(m_x), 3'(m_y), 2'(m_head), m_pulse, (m_st == 1)};
      got_v = {head_x, head_y, heading, step_pulse, running};
      checks++;
      if (got_v !== exp_v)
        $display("FAIL random_c%0d: got x=%0d y=%0d hd=%0d sp=%0d run=%0d want x=%0d y=%0d hd=%0d sp=%0d run=%0d",
                 c, head_x, head_y, heading, step_pulse, running, m_x, m_y, m_head, m_pulse, m_st == 1);
      else passes++;
      if (c == 750) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
      if (hold == 0) begin
        r = int'($urandom_range(0, 15));
        if (r < 10)      direction = 3'(r % 4);
        else if (r < 12) direction = 3'b100;
        else             direction = 3'(5 + r % 3);
        hold = int'($urandom_range(1, 10));
      end else begin
        hold--;
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_up();
    test_wrap_right();
    test_reverse();
    test_wrap_left();
    test_pause();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
